aes_enc_round_ctrl: RTL and testbench

- Iterative AES-128 encryption controller.
- Accepts a plaintext and cipher key over a valid/ready handshake and performs the initial AddRoundKey internally.
- Sequences 10 rounds through an external combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and an external key-expansion step.
- Presents the ciphertext on a valid/ready output handshake. It is the sequencer that makes one round datapath serve all rounds.

---
 rtl/aes_enc_round_ctrl.sv | 104 ++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption sequencer: folds the initial AddRoundKey into the accept
// edge, then reuses one external combinational round/key-expansion datapath for all NR rounds.
module aes_enc_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic [127:0] dp_state_o,
  output logic [127:0] dp_key_o,
  output logic [7:0]   dp_rcon_o,
  output logic         dp_final_o,
  input  logic [127:0] dp_key_i,
  input  logic [127:0] dp_state_i,
  output logic         busy,
  output logic [3:0]   round_o
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         st, st_nxt;
  logic [127:0] state_q, key_q, out_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic         last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign last = (round_q == 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (last) st_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Round/key/rcon registers advance in lockstep with the FSM; the final round result is
  // captured separately so out_text is a pure register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      rcon_q  <= 8'h01;
      round_q <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          state_q <= in_text ^ in_key;
          key_q   <= in_key;
          rcon_q  <= 8'h01;
          round_q <= 4'd1;
        end
        ROUND: begin
          state_q <= dp_state_i;
          key_q   <= dp_key_i;
          rcon_q  <= xtime(rcon_q);
          if (last) out_q   <= dp_state_i;
          else      round_q <= round_q + 4'd1;
        end
        DONE: if (out_ready) round_q <= '0;
        default: ;
      endcase
    end
  end

  assign out_text   = out_q;
  assign dp_state_o = state_q;
  assign dp_key_o   = key_q;
  assign dp_rcon_o  = rcon_q;
  assign dp_final_o = last;
  assign round_o    = round_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed bench for aes_enc_round_ctrl; a golden AES round and key-expansion model
// stands in for the external datapath.
module tb_aes_enc_round_ctrl;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_TEXT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, dp_final_o, busy;
  logic [127:0] in_text, in_key, out_text, dp_state_o, dp_key_o, dp_key_i, dp_state_i;
  logic [7:0]   dp_rcon_o;
  logic [3:0]   round_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes_enc_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_text(in_text), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_text(out_text), .dp_state_o(dp_state_o), .dp_key_o(dp_key_o),
    .dp_rcon_o(dp_rcon_o), .dp_final_o(dp_final_o), .dp_key_i(dp_key_i),
    .dp_state_i(dp_state_i), .busy(busy), .round_o(round_o)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   t0, t1, t2, t3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[8*(15-i) +: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, t0) ^ gmul(8'h03, t1) ^ t2 ^ t3;
        b[4*c+1] = t0 ^ gmul(8'h02, t1) ^ gmul(8'h03, t2) ^ t3;
        b[4*c+2] = t0 ^ t1 ^ gmul(8'h02, t2) ^ gmul(8'h03, t3);
        b[4*c+3] = gmul(8'h03, t0) ^ t1 ^ t2 ^ gmul(8'h02, t3);
      end
    for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = b[i];
    return o ^ rk;
  endfunction

  assign dp_key_i   = kexp(dp_key_o, dp_rcon_o);
  assign dp_state_i = aes_round(dp_state_o, dp_key_i, dp_final_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  logic [7:0]   rcon_tab [10];
  logic [127:0] held;
  int           n;
  logic         seen;

  initial begin
    rcon_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_text   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_round",     round_o,   4'd0);
    check("rst_out_text",  out_text,  '0);

    // FIPS-197 C.1 with latency measurement
    in_text = C1_TEXT; in_key = C1_KEY; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_text = '0; in_key = '0;
    check("c1_in_ready_busy", in_ready, 1'b0);
    check("c1_busy",          busy,     1'b1);
    check("c1_round1",        round_o,  4'd1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("c1_latency", 128'(n), 128'd10);
    check("c1_ct", out_text, C1_CT);
    step();
    check("c1_idle_in_ready", in_ready, 1'b1);
    check("c1_idle_round",    round_o,  4'd0);

    // FIPS-197 B with per-round rcon/final checks, then backpressure
    in_text = B_TEXT; in_key = B_KEY; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      check($sformatf("b_round_r%0d", r), round_o,    128'(r));
      check($sformatf("b_rcon_r%0d", r),  dp_rcon_o,  rcon_tab[r-1]);
      check($sformatf("b_final_r%0d", r), dp_final_o, (r == 10));
      step();
    end
    check("b_out_valid", out_valid, 1'b1);
    check("b_ct", out_text, B_CT);
    held = out_text;
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0];
      in_text  = {$urandom, $urandom, $urandom, $urandom};
      step();
      check($sformatf("bp_stable_%0d", i), out_text,  held);
      check($sformatf("bp_valid_%0d", i),  out_valid, 1'b1);
      check($sformatf("bp_ready_%0d", i),  in_ready,  1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_release_in_ready",  in_ready,  1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);
    check("bp_release_busy",      busy,      1'b0);
    check("bp_release_round",     round_o,   4'd0);

    // Back-to-back: in_valid held high, inputs change right after the first accept
    in_text = C1_TEXT; in_key = C1_KEY; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_text = B_TEXT; in_key = B_KEY;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 10) begin
        check("b2b_first_valid", out_valid, 1'b1);
        check("b2b_first_ct",    out_text,  C1_CT);
      end
      if (i == 11) check("b2b_idle_gap", in_ready, 1'b1);
    end
    check("b2b_second_accept", round_o, 4'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("b2b_second_valid", out_valid, 1'b1);
    check("b2b_second_ct",    out_text,  B_CT);
    step();

    // Reset in round 5 discards the block
    in_text = C1_TEXT; in_key = C1_KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (round_o != 4'd5 && n < 20) begin step(); n++; end
    check("mid_reach_round5", round_o, 4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready,  1'b1);
    check("mid_rst_busy",     busy,      1'b0);
    check("mid_rst_round",    round_o,   4'd0);
    seen = out_valid;
    for (int i = 0; i < 15; i++) begin step(); seen = seen | out_valid; end
    check("mid_no_out_valid", seen, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("post_rst_latency", 128'(n), 128'd10);
    check("post_rst_ct", out_text, C1_CT);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
